// File: rtl/vga_image_blit.sv
// vga_image_blit: places an upscaled ROM image at a screen offset, pipelined to match ROM latency.
// Optional one-pixel frame around the window when VGA_IMG_BORDER_EN is defined.
module vga_image_blit #(
  parameter int          H_DISP       = 640,
  parameter int          V_DISP       = 480,
  parameter int          IMG_W        = 400,
  parameter int          IMG_H        = 300,
  parameter int          SCALE_SHIFT  = 1,
  parameter int          X_OFS        = 0,
  parameter int          Y_OFS        = 0,
  parameter int          ADDR_W       = 17,
  parameter int          ROM_LAT      = 1,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter logic [23:0] BORDER_COLOR = 24'hffffff
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic [10:0]       vga_xpos,
  input  logic [10:0]       vga_ypos,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_q,
  output logic [23:0]       vga_data
);
  localparam int X_END = (X_OFS + (IMG_W << SCALE_SHIFT) < H_DISP) ? X_OFS + (IMG_W << SCALE_SHIFT) : H_DISP;
  localparam int Y_END = (Y_OFS + (IMG_H << SCALE_SHIFT) < V_DISP) ? Y_OFS + (IMG_H << SCALE_SHIFT) : V_DISP;
  localparam logic [2:0] SUB_MAX = 3'((1 << SCALE_SHIFT) - 1);
  typedef enum logic {UNARMED, ARMED} state_t;
  state_t state, state_nx;
  logic [10:0] ypos_d, col_off;
  logic [ADDR_W-1:0] row_base, row_base_nx;
  logic [2:0] sub, sub_nx;
  logic line_ev, at_top, row_in, in_win, ring;
  logic [ROM_LAT:0] win_p, brd_p;
  int xi, yi;
  assign xi = {21'b0, vga_xpos};
  assign yi = {21'b0, vga_ypos};
  assign line_ev = vga_ypos != ypos_d;
  assign at_top = vga_ypos == 11'(Y_OFS);
  assign row_in = yi >= Y_OFS && yi < Y_END;
  assign in_win = state == ARMED && row_in && xi >= X_OFS && xi < X_END;
  assign col_off = vga_xpos - 11'(X_OFS);
`ifdef VGA_IMG_BORDER_EN
  assign ring = state == ARMED && !in_win && xi >= X_OFS - 1 && xi <= X_END && yi >= Y_OFS - 1 && yi <= Y_END
                && xi < H_DISP && yi < V_DISP;
`else
  assign ring = 1'b0;
`endif
  // Frame-top line event always re-synchronises, so a glitched frame recovers at the next top.
  always_comb begin
    state_nx = state;
    row_base_nx = row_base;
    sub_nx = sub;
    if (line_ev && at_top) begin
      state_nx = ARMED;
      row_base_nx = '0;
      sub_nx = '0;
    end else if (line_ev && row_in && state == ARMED) begin
      row_base_nx = sub == SUB_MAX ? row_base + ADDR_W'(IMG_W) : row_base;
      sub_nx = sub == SUB_MAX ? 3'd0 : sub + 3'd1;
    end
  end
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNARMED;
      ypos_d <= '0;
      row_base <= '0;
      sub <= '0;
      rom_addr <= '0;
      win_p <= '0;
      brd_p <= '0;
      vga_data <= '0;
    end else begin
      state <= state_nx;
      ypos_d <= vga_ypos;
      row_base <= row_base_nx;
      sub <= sub_nx;
      rom_addr <= in_win ? row_base + ADDR_W'(col_off >> SCALE_SHIFT) : rom_addr;
      win_p <= {win_p[ROM_LAT-1:0], in_win};
      brd_p <= {brd_p[ROM_LAT-1:0], ring};
      vga_data <= win_p[ROM_LAT] ? rom_q : brd_p[ROM_LAT] ? BORDER_COLOR : BG_COLOR;
    end
  end
endmodule
